// File: rtl/mac_seq_ctrl.sv
`timescale 1ns/1ps
// mac_seq_ctrl: command/operand sequencer and strobe owner for the iterative shift-add MAC.
// Optional feature macro MACSEQ_CNT_EN adds the 8-bit saturating mac_count output.
module mac_seq_ctrl #(
  parameter int OP_W  = 8,
  parameter int ACC_W = 24,
  parameter int ITER  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       in_data,
  input  logic [1:0]       in_cmd,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OP_W-1:0]  dp_a,
  output logic [OP_W-1:0]  dp_b,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_clr,
  input  logic [ACC_W-1:0] dp_acc,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             busy
`ifdef MACSEQ_CNT_EN
  ,
  output logic [7:0]       mac_count
`endif
);

  localparam int NB = ACC_W / 8;
  localparam int CW = $clog2(ITER + 1);
  localparam int IW = $clog2(NB + 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(ITER - 1);
  localparam logic [IW-1:0] IDX_END   = IW'(NB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_B,
    S_LOAD,
    S_RUN,
    S_READ
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_idx;
  logic [ACC_W-1:0]   r_snap;
  logic [OP_W-1:0]    r_a;
  logic [OP_W-1:0]    r_b;
  logic [7:0]         r_out;
  logic               r_load;
  logic               r_step;
  logic               r_clr;
  logic               r_ov;
  logic               r_busy;
  logic               w_accept;
  logic [7:0]         w_byte;
`ifdef MACSEQ_CNT_EN
  logic [7:0]         r_macs;
`endif

  assign in_ready = ena & (r_state == S_IDLE | r_state == S_WAIT_B);
  assign w_accept = in_valid & in_ready;
  assign w_byte   = 8'(r_snap >> {r_idx, 3'b000});

  // Strobes are held in their registers while frozen and masked here, so a
  // paused step is re-issued (not lost) once ena returns.
  assign dp_load   = r_load & ena;
  assign dp_step   = r_step & ena;
  assign dp_clr    = r_clr  & ena;
  assign out_valid = r_ov   & ena;
  assign dp_a      = r_a;
  assign dp_b      = r_b;
  assign out_data  = r_out;
  assign busy      = r_busy;
`ifdef MACSEQ_CNT_EN
  assign mac_count = r_macs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_load  <= 1'b0;
      r_step  <= 1'b0;
      r_clr   <= 1'b0;
      r_ov    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef MACSEQ_CNT_EN
      r_macs  <= '0;
`endif
    end else if (ena) begin
      r_load <= 1'b0;
      r_step <= 1'b0;
      r_clr  <= 1'b0;
      r_ov   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unique case (in_cmd)
              2'b00: begin
                r_a     <= OP_W'(in_data);
                r_state <= S_WAIT_B;
              end
              2'b01: begin
                r_clr <= 1'b1;
`ifdef MACSEQ_CNT_EN
                r_macs <= '0;
`endif
              end
              2'b10: begin
                // Byte 0 is emitted on entry; r_idx then names the next byte.
                r_snap  <= dp_acc;
                r_out   <= dp_acc[7:0];
                r_ov    <= 1'b1;
                r_idx   <= IW'(1);
                r_busy  <= 1'b1;
                r_state <= S_READ;
              end
              default: ;
            endcase
          end
        end
        S_WAIT_B: begin
          if (w_accept) begin
            r_b     <= OP_W'(in_data);
            r_load  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_step  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RUN;
`ifdef MACSEQ_CNT_EN
          if (r_macs != 8'hFF) r_macs <= r_macs + 8'd1;
`endif
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == STEP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_step <= 1'b1;
          end
        end
        S_READ: begin
          if (r_idx == IDX_END) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_out <= w_byte;
            r_ov  <= 1'b1;
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
`timescale 1ns/1ps
// tb_mac_seq_ctrl: directed and randomized checks of mac_seq_ctrl against a
// bench-side shift-add datapath and an arithmetic accumulator model.
module tb_mac_seq_ctrl;

  localparam int ITER = 8;
  localparam logic [1:0] C_OPER = 2'b00;
  localparam logic [1:0] C_CLR  = 2'b01;
  localparam logic [1:0] C_READ = 2'b10;
  localparam logic [1:0] C_NOP  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  in_data;
  logic [1:0]  in_cmd;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dp_a, dp_b;
  logic        dp_load, dp_step, dp_clr;
  logic [23:0] dp_acc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
`ifdef MACSEQ_CNT_EN
  logic [7:0]  mac_count;
`endif

  mac_seq_ctrl #(.OP_W(8), .ACC_W(24), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_data(in_data), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_load(dp_load), .dp_step(dp_step), .dp_clr(dp_clr),
    .dp_acc(dp_acc), .out_data(out_data), .out_valid(out_valid), .busy(busy)
`ifdef MACSEQ_CNT_EN
    , .mac_count(mac_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench datapath: accumulates a*b once ITER steps have followed a load.
  int unsigned m_acc = 0, m_a = 0, m_b = 0, m_s = 0;
  int          n_step = 0, n_load = 0, n_clr = 0, n_busy = 0, n_ovl = 0;
  int          stepq[$];
  logic [7:0]  outq[$];
  logic [7:0]  ld_a, ld_b;
  assign dp_acc = m_acc[23:0];

  always @(negedge clk) begin
    if (dp_clr) m_acc = 0;
    if (dp_load) begin
      n_load++; ld_a = dp_a; ld_b = dp_b;
      m_a = dp_a; m_b = dp_b; m_s = 0;
    end
    if (dp_step) begin
      n_step++; stepq.push_back(cyc); m_s++;
      if (m_s == ITER) m_acc = (m_acc + m_a * m_b) & 32'h00FF_FFFF;
    end
    if (dp_clr) n_clr++;
    if (busy) n_busy++;
    if (out_valid) outq.push_back(out_data);
    if (dp_step && (dp_load || dp_clr)) n_ovl++;
  end

  int          n_chk = 0, n_fail = 0;
  int          acc_cyc, acc_b;
  logic [23:0] exp_acc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d);
    int k = 0;
    in_valid = 1'b1; in_cmd = c; in_data = d;
    while (!in_ready && k < 300) begin tick(); k++; end
    check("beat_accept", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0; in_cmd = C_NOP;
  endtask

  task automatic wait_idle();
    int k = 0;
    tick();
    while (busy && k < 300) begin tick(); k++; end
    check("idle_reached", {31'd0, busy}, 0);
    tick(); tick();
  endtask

  task automatic mac(input logic [7:0] a, input logic [7:0] b, input logic [1:0] bc);
    send(C_OPER, a);
    send(bc, b);
    acc_b = acc_cyc;
    wait_idle();
    exp_acc = exp_acc + 24'(a) * 24'(b);
  endtask

  task automatic read_check(input string tag);
    int b0 = outq.size();
    logic [23:0] got = '0;
    send(C_READ, 8'h00);
    wait_idle();
    check({tag, "_nbytes"}, outq.size() - b0, 3);
    if (outq.size() >= b0 + 3) got = {outq[b0+2], outq[b0+1], outq[b0]};
    check(tag, {8'd0, got}, {8'd0, exp_acc});
  endtask

  initial begin
    int bs, bb, bl, bq, bc, ns, k;
    logic [7:0] a, b, a2, b2;

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_cmd = C_NOP; in_data = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_strobes", {27'd0, dp_load, dp_step, dp_clr, out_valid, busy}, 0);
    check("rst_ready", {31'd0, in_ready}, 1);
    check("rst_regs", {8'd0, dp_a, dp_b, out_data}, 0);
    rst_n = 1'b1;
    tick();

    // OPER 3, OPER 5
    bs = n_step; bb = n_busy; bl = n_load; bq = stepq.size();
    mac(8'd3, 8'd5, C_OPER);
    check("load_count", n_load - bl, 1);
    check("load_ab", {16'd0, ld_a, ld_b}, 32'h0305);
    check("step_count", n_step - bs, 8);
    check("busy_cycles", n_busy - bb, 9);
    check("b_to_step_lat", stepq[bq] - (acc_b - 1), 2);
    read_check("read_15");

    // CLR then two 255*255 MACs
    bc = n_clr;
    send(C_CLR, 8'h00); wait_idle(); exp_acc = '0;
    check("clr_pulses", n_clr - bc, 1);
    mac(8'd255, 8'd255, C_OPER);
    mac(8'd255, 8'd255, C_OPER);
    check("acc_130050", {8'd0, exp_acc}, 130050);
    read_check("read_130050");

    // Freeze for 5 cycles after the 3rd step
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    bs = n_step; bb = n_busy;
    send(C_OPER, a); send(C_OPER, b);
    k = 0;
    while (n_step - bs < 3 && k < 50) begin tick(); k++; end
    check("pause_reach3", n_step - bs, 3);
    ena = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      check("pause_step", {31'd0, dp_step}, 0);
      check("pause_ready", {31'd0, in_ready}, 0);
      tick();
    end
    ena = 1'b1;
    wait_idle();
    exp_acc = exp_acc + 24'(a) * 24'(b);
    check("pause_steps", n_step - bs, 8);
    check("pause_busy", n_busy - bb, 14);
    read_check("read_pause");

    // Back-to-back: next OPER held valid during RUN
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    a2 = 8'($urandom_range(0, 255)); b2 = 8'($urandom_range(0, 255));
    bs = n_step;
    send(C_OPER, a); send(C_OPER, b);
    send(C_OPER, a2);
    check("b2b_accept", (acc_cyc - 1) - stepq[stepq.size()-1], 1);
    send(C_OPER, b2);
    wait_idle();
    exp_acc = exp_acc + 24'(a) * 24'(b) + 24'(a2) * 24'(b2);
    check("b2b_steps", n_step - bs, 16);
    read_check("read_b2b");

    // Randomized MACs with stray NOP/CLR beats and arbitrary B-beat commands
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        send(C_CLR, 8'($urandom)); wait_idle(); exp_acc = '0;
      end
      if ($urandom_range(0, 3) == 0) send(C_NOP, 8'($urandom));
      bs = n_step;
      mac(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      check("rnd_steps", n_step - bs, 8);
      if (i % 4 == 3) read_check("rnd_read");
    end

    // Reset in the middle of RUN
    bs = n_step;
    send(C_OPER, 8'h7A); send(C_OPER, 8'h11);
    k = 0;
    while (n_step - bs < 2 && k < 50) begin tick(); k++; end
    rst_n = 1'b0; #1;
    check("midrst_strobes", {27'd0, dp_load, dp_step, dp_clr, out_valid, busy}, 0);
    check("midrst_ready", {31'd0, in_ready}, 1);
    tick(); tick();
    rst_n = 1'b1;
    ns = n_step;
    repeat (10) tick();
    check("midrst_nostep", n_step - ns, 0);
    read_check("read_after_rst");

`ifdef MACSEQ_CNT_EN
    check("cnt_rst", {24'd0, mac_count}, 0);
    mac(8'd1, 8'd1, C_OPER);
    check("cnt_one", {24'd0, mac_count}, 1);
    for (int i = 0; i < 299; i++) mac(8'd1, 8'd1, C_OPER);
    check("cnt_sat", {24'd0, mac_count}, 255);
    send(C_CLR, 8'h00); wait_idle(); exp_acc = '0;
    check("cnt_clr", {24'd0, mac_count}, 0);
    read_check("read_cnt_clr");
`endif

    check("no_strobe_overlap", n_ovl, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
